pe_input_loader: RTL and testbench
==================================

# pe_input_loader

- Upstream staging stage for `PE`: accepts a serial stream of FP32 activations/weights on a valid/ready handshake and packs them into 8-lane groups.
- Presents each completed group on `out0`..`out7` with a one-cycle `o_vld` pulse; these connect directly to PE `in0`..`in7` and `i_vld`.
- Short groups terminated by `s_last` are zero-padded.
- A programmable gap counter enforces minimum spacing between PE launches.

## Interface
- `GAP`, 4: minimum cycles between consecutive `o_vld` pulses; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `s_data`  in  32  FP32 input word.
- `s_vld`  in  1  `s_data` valid.
- `s_last`  in  1  marks the final word of a group; qualified by `s_vld`.
- `s_rdy`  out  1  loader can accept a word.
- `out0`..`out7`  out  32 each  packed lanes to PE; `out0` holds the first word accepted in the group.
- `o_vld`  out  1  one-cycle launch strobe to PE `i_vld`.
- `busy`  out  1  asserted when fill count != 0, or pending, or gap count != 0.

## Operation
- State: fill bank `f0..f7` (32b each), 3-bit fill count `cnt`, `pend` flag, 8-bit `gap_cnt`, output regs `out0..7`, `o_vld` reg.
- `s_rdy = rst & !pend`. Transfer occurs when `s_vld & s_rdy`.
- Accept, not completing a group: `f[cnt] <= s_data`, `cnt <= cnt+1`.
- Accept with `cnt==7` or `s_last==1`: store the word, set `pend`, `cnt <= 0`.
- Lanes above the final index read as 0x00000000. Fill-bank lanes are cleared on every launch, so no stale data survives.
- Launch, when `pend & gap_cnt==0`:
  - `outN <= fN` for all lanes.
  - `o_vld <= 1` for exactly one cycle.
  - `pend <= 0`, all `fN <= 0`.
  - `gap_cnt <= GAP-1`.
- Otherwise `o_vld <= 0`, and `gap_cnt` decrements when nonzero (saturates at 0).
- `out0..7` hold their value between launches. PE samples them only in the `o_vld` cycle.
- `s_last` with `s_vld` low is ignored.
- A group always holds between 1 and 8 words.
- No accept occurs in a cycle where `pend=1`, so a launch never races a new word.
- Pure packing/padding: no arithmetic on data, except the optional FTZ (see Configuration).

## Timing
- Reset values (async, while `rst=0`):
  - `out0..7 = 0`, `o_vld = 0`, `s_rdy = 0`, `busy = 0`.
  - `cnt = 0`, `pend = 0`, `gap_cnt = 0`, fill bank = 0.
- First edge after `rst` rises: `s_rdy = 1`.
- Latency:
  - Word completing a group is accepted at edge E.
  - `pend` is high after E and `s_rdy` drops.
  - If `gap_cnt==0`, launch occurs at E+1: `o_vld` is high from E+1 to E+2 and `s_rdy` returns high after E+1.
- Full-rate throughput: 9 cycles per 8-word group (8 accepts + 1 launch cycle).
- Spacing between `o_vld` pulses is at least `max(GAP, words+1)` cycles.
- If the gap counter is still running when a group completes:
  - `pend` holds, `s_rdy` stays low, and the launch waits for `gap_cnt==0`.
  - No word is dropped or duplicated.
- Reset mid-group or while `pend`: the partial or pending group is discarded; no `o_vld` is issued.

## Configuration
- `PE_LOADER_FTZ_EN` defined:
  - At accept, a subnormal word (exponent==0 and mantissa!=0) is replaced by a signed zero: `{s_data[31], 31'b0}`.
  - All other words pass unchanged.
- Undefined: words are stored bit-exact, subnormals included.
- Padding lanes are +0.0 in both builds.

## Test plan
- Full group, `GAP=4`:
  - Stimulus: stream 3a83126f, 3aa1be2b, 3e6f9db2, 3d9fbe77, 3f65a1cb, 3da0663c, 3d9fbe77, 00000000 back-to-back with `s_rdy` honoured.
  - Required: a single `o_vld` pulse 1 cycle after the 8th accept; `out0..7` equal the stream in order; `s_rdy` low for exactly 1 cycle.
- Short group:
  - Stimulus: 3 words 3f800000, 40000000, 40400000 with `s_last` on the third.
  - Required: `out0..2` equal the words, `out3..7` = 00000000; `o_vld` 1 cycle after the third accept.
- Gap throttling, `GAP=6`:
  - Stimulus: two 1-word groups (`s_last` on each) sent back-to-back.
  - Required: the `o_vld` pulses are exactly 6 cycles apart; `s_rdy` stays low while the second group is pending.
- Backpressure and idle:
  - Stimulus: deassert `s_vld` randomly mid-group.
  - Required: no dropped or duplicated words; `busy` stays high until `gap_cnt` reaches 0 after the launch.
- Reset mid-group:
  - Stimulus: accept 5 words, then pulse `rst` low for 1 cycle, then send an 8-word group.
  - Required: no `o_vld` for the aborted group; the next `o_vld` carries only the new 8 words.
- FTZ:
  - Stimulus: send 80000001 and 00400000 as a 2-word group.
  - Required: with `PE_LOADER_FTZ_EN`, `out0`=80000000 and `out1`=00000000; without it, `out0`=80000001 and `out1`=00400000.

Source files
------------

// File: rtl/pe_input_loader.sv
// Packs a serial FP32 valid/ready stream into 8-lane groups for the PE, zero-padding short groups,
// and enforces a minimum launch spacing of GAP cycles. Optional build macro: PE_LOADER_FTZ_EN.
module pe_input_loader #(
    parameter int GAP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic        s_vld,
    input  logic        s_last,
    output logic        s_rdy,
    output logic [31:0] out0,
    output logic [31:0] out1,
    output logic [31:0] out2,
    output logic [31:0] out3,
    output logic [31:0] out4,
    output logic [31:0] out5,
    output logic [31:0] out6,
    output logic [31:0] out7,
    output logic        o_vld,
    output logic        busy
);

    localparam logic [7:0] GAP_RELOAD = 8'(GAP - 1);

    logic [31:0] f_q   [8];
    logic [31:0] f_d   [8];
    logic [31:0] out_q [8];
    logic [31:0] out_d [8];
    logic [2:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [7:0]  gap_q, gap_d;
    logic        o_vld_q, o_vld_d;
    logic        accept;
    logic        launch;
    logic [31:0] word_in;

`ifdef PE_LOADER_FTZ_EN
    // Subnormals flush to a zero that keeps the sign bit.
    assign word_in = (s_data[30:23] == 8'd0 && s_data[22:0] != 23'd0) ? {s_data[31], 31'b0} : s_data;
`else
    assign word_in = s_data;
`endif

    // s_rdy is low whenever a completed group is waiting, so accept and launch never coincide.
    assign s_rdy  = rst & ~pend_q;
    assign accept = s_vld & s_rdy;
    assign launch = pend_q & (gap_q == 8'd0);

    always_comb begin
        f_d     = f_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        gap_d   = gap_q;
        o_vld_d = 1'b0;

        if (launch) begin
            out_d   = f_q;
            o_vld_d = 1'b1;
            pend_d  = 1'b0;
            gap_d   = GAP_RELOAD;
            for (int i = 0; i < 8; i++) f_d[i] = 32'd0;
        end else if (gap_q != 8'd0) begin
            gap_d = gap_q - 8'd1;
        end

        if (accept) begin
            f_d[cnt_q] = word_in;
            if (cnt_q == 3'd7 || s_last) begin
                pend_d = 1'b1;
                cnt_d  = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                f_q[i]   <= 32'd0;
                out_q[i] <= 32'd0;
            end
            cnt_q   <= 3'd0;
            pend_q  <= 1'b0;
            gap_q   <= 8'd0;
            o_vld_q <= 1'b0;
        end else begin
            f_q     <= f_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            gap_q   <= gap_d;
            o_vld_q <= o_vld_d;
        end
    end

    assign out0  = out_q[0];
    assign out1  = out_q[1];
    assign out2  = out_q[2];
    assign out3  = out_q[3];
    assign out4  = out_q[4];
    assign out5  = out_q[5];
    assign out6  = out_q[6];
    assign out7  = out_q[7];
    assign o_vld = o_vld_q;
    assign busy  = (cnt_q != 3'd0) | pend_q | (gap_q != 8'd0);

endmodule

// File: tb/tb_pe_input_loader.sv
// Directed bench for pe_input_loader: GAP=4 instance for packing/padding/reset/FTZ, GAP=6 instance for throttling.
module tb_pe_input_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_vld = 1'b0;
    logic        s_last = 1'b0;
    logic        s_rdy, o_vld, busy;
    logic [31:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic [31:0] outs [8];

    logic [31:0] s_data6 = '0;
    logic        s_vld6 = 1'b0;
    logic        s_last6 = 1'b0;
    logic        s_rdy6, o_vld6, busy6;
    logic [31:0] p0, p1, p2, p3, p4, p5, p6, p7;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    pe_input_loader #(.GAP(4)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_vld(s_vld), .s_last(s_last), .s_rdy(s_rdy),
        .out0(o0), .out1(o1), .out2(o2), .out3(o3), .out4(o4), .out5(o5), .out6(o6), .out7(o7),
        .o_vld(o_vld), .busy(busy)
    );

    pe_input_loader #(.GAP(6)) dut6 (
        .clk(clk), .rst(rst), .s_data(s_data6), .s_vld(s_vld6), .s_last(s_last6), .s_rdy(s_rdy6),
        .out0(p0), .out1(p1), .out2(p2), .out3(p3), .out4(p4), .out5(p5), .out6(p6), .out7(p7),
        .o_vld(o_vld6), .busy(busy6)
    );

    assign outs[0] = o0;
    assign outs[1] = o1;
    assign outs[2] = o2;
    assign outs[3] = o3;
    assign outs[4] = o4;
    assign outs[5] = o5;
    assign outs[6] = o6;
    assign outs[7] = o7;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offers one word on the GAP=4 instance and returns 1 ns after the edge that took it.
    task automatic send_word(input logic [31:0] d, input logic last);
        bit taken = 1'b0;
        s_data = d;
        s_last = last;
        s_vld  = 1'b1;
        for (int i = 0; i < 64 && !taken; i++) begin
            taken = s_rdy;
            step();
        end
        s_vld  = 1'b0;
        s_last = 1'b0;
        exp_q.push_back(d);
        chk("send_accept", {31'd0, taken}, 32'd1);
    endtask

    // Called right after the closing accept: launch must land exactly one edge later.
    task automatic finish_group(input int n, input string tag);
        logic [31:0] e;
        chk({tag, "_pend_no_vld"}, {31'd0, o_vld}, 32'd0);
        chk({tag, "_pend_rdy_low"}, {31'd0, s_rdy}, 32'd0);
        step();
        chk({tag, "_vld"}, {31'd0, o_vld}, 32'd1);
        chk({tag, "_rdy_back"}, {31'd0, s_rdy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            e = (i < n && exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
            chk($sformatf("%s_lane%0d", tag, i), outs[i], e);
        end
        step();
        chk({tag, "_vld_one_cycle"}, {31'd0, o_vld}, 32'd0);
    endtask

    initial begin
        int cyc;
        bit rdy_bad;
        bit vld_seen;

        // Reset state
        step();
        chk("rst_s_rdy", {31'd0, s_rdy}, 32'd0);
        chk("rst_o_vld", {31'd0, o_vld}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out0", o0, 32'd0);
        chk("rst_out7", o7, 32'd0);
        rst = 1'b1;
        step();
        chk("post_rst_s_rdy", {31'd0, s_rdy}, 32'd1);

        // Full 8-word group, back-to-back
        send_word(32'h3a83126f, 1'b0);
        chk("busy_mid_group", {31'd0, busy}, 32'd1);
        send_word(32'h3aa1be2b, 1'b0);
        send_word(32'h3e6f9db2, 1'b0);
        send_word(32'h3d9fbe77, 1'b0);
        send_word(32'h3f65a1cb, 1'b0);
        send_word(32'h3da0663c, 1'b0);
        send_word(32'h3d9fbe77, 1'b0);
        send_word(32'h00000000, 1'b0);
        finish_group(8, "full");
        chk("full_hold_out0", o0, 32'h3a83126f);
        chk("full_busy_gap2", {31'd0, busy}, 32'd1);
        step();
        chk("full_busy_gap1", {31'd0, busy}, 32'd1);
        step();
        chk("full_busy_gap0", {31'd0, busy}, 32'd0);

        // Short group padded with zeros
        send_word(32'h3f800000, 1'b0);
        send_word(32'h40000000, 1'b0);
        send_word(32'h40400000, 1'b1);
        finish_group(3, "short");
        step();
        step();

        // Gap throttling on the GAP=6 instance
        s_data6 = 32'h11111111;
        s_last6 = 1'b1;
        s_vld6  = 1'b1;
        chk("gap_first_rdy", {31'd0, s_rdy6}, 32'd1);
        step();
        s_vld6 = 1'b0;
        chk("gap_first_pend", {31'd0, s_rdy6}, 32'd0);
        step();
        chk("gap_first_vld", {31'd0, o_vld6}, 32'd1);
        chk("gap_first_out0", p0, 32'h11111111);
        s_data6 = 32'h22222222;
        s_vld6  = 1'b1;
        chk("gap_second_rdy", {31'd0, s_rdy6}, 32'd1);
        step();
        s_vld6  = 1'b0;
        s_last6 = 1'b0;
        chk("gap_second_rdy_low", {31'd0, s_rdy6}, 32'd0);
        cyc = 1;
        rdy_bad = 1'b0;
        vld_seen = 1'b0;
        for (int i = 0; i < 20 && !vld_seen; i++) begin
            step();
            cyc++;
            if (o_vld6) vld_seen = 1'b1;
            else if (s_rdy6) rdy_bad = 1'b1;
        end
        chk("gap_second_vld_seen", {31'd0, vld_seen}, 32'd1);
        chk("gap_spacing", cyc, 32'd6);
        chk("gap_rdy_held_low", {31'd0, rdy_bad}, 32'd0);
        chk("gap_second_out0", p0, 32'h22222222);
        chk("gap_second_out1_pad", p1, 32'd0);

        // Backpressure: idle cycles and a stray s_last without s_vld
        send_word(32'h3f000000, 1'b0);
        send_word(32'hbf800000, 1'b0);
        s_last = 1'b1;
        step();
        s_last = 1'b0;
        chk("bp_busy_idle", {31'd0, busy}, 32'd1);
        chk("bp_no_vld_idle", {31'd0, o_vld}, 32'd0);
        send_word(32'h41200000, 1'b0);
        for (int i = 0; i < $urandom_range(1, 3); i++) step();
        send_word(32'hc1200000, 1'b0);
        send_word(32'h3c23d70a, 1'b0);
        for (int i = 0; i < $urandom_range(1, 3); i++) step();
        send_word(32'h7f7fffff, 1'b0);
        send_word(32'h00800000, 1'b0);
        for (int i = 0; i < $urandom_range(1, 3); i++) step();
        send_word(32'hff800000, 1'b0);
        finish_group(8, "bp");
        chk("bp_busy_gap2", {31'd0, busy}, 32'd1);
        step();
        chk("bp_busy_gap1", {31'd0, busy}, 32'd1);
        step();
        chk("bp_busy_gap0", {31'd0, busy}, 32'd0);

        // Reset mid-group: 5 words then discard
        send_word(32'h12345678, 1'b0);
        send_word(32'h23456789, 1'b0);
        send_word(32'h3456789a, 1'b0);
        send_word(32'h456789ab, 1'b0);
        send_word(32'h56789abc, 1'b0);
        exp_q.delete();
        rst = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_s_rdy", {31'd0, s_rdy}, 32'd0);
        chk("midrst_out0", o0, 32'd0);
        step();
        rst = 1'b1;
        vld_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (o_vld) vld_seen = 1'b1;
        end
        chk("midrst_no_vld", {31'd0, vld_seen}, 32'd0);
        send_word(32'h40a00000, 1'b0);
        send_word(32'h40c00000, 1'b0);
        send_word(32'h40e00000, 1'b0);
        send_word(32'h41000000, 1'b0);
        send_word(32'h41100000, 1'b0);
        send_word(32'h41200000, 1'b0);
        send_word(32'h41300000, 1'b0);
        send_word(32'h41400000, 1'b0);
        finish_group(8, "after_rst");
        step();
        step();

        // Subnormal handling
        send_word(32'h80000001, 1'b0);
        send_word(32'h00400000, 1'b1);
        exp_q.delete();
`ifdef PE_LOADER_FTZ_EN
        exp_q.push_back(32'h80000000);
        exp_q.push_back(32'h00000000);
`else
        exp_q.push_back(32'h80000001);
        exp_q.push_back(32'h00400000);
`endif
        finish_group(2, "ftz");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
